operand_fifo: RTL

//  Synchronous FIFO buffering 9-bit operand words (x/y/z-width datapath) with

---
 rtl/operand_fifo.sv | 127 ++++++++++++
 1 files changed

// File: rtl/operand_fifo.sv
// Operand FIFO: valid/ready buffer with registered head word, occupancy and sticky handshake error.
// Optional OPERAND_FIFO_PARITY_EN adds a stored even-parity bit per entry and a sticky parity_err output.
module operand_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW:0]      count,
  input  logic             flush,
`ifdef OPERAND_FIFO_PARITY_EN
  output logic             parity_err,
`endif
  output logic             err
);

`ifdef OPERAND_FIFO_PARITY_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
  logic [AW:0]      count_r, count_s;
  logic [WIDTH-1:0] out_data_r, head_s;
  logic             in_ready_r, out_valid_r, stall_r, err_r;
  logic             push_s, pop_s;
  logic [EW-1:0]    entry_s;

  assign push_s = in_valid & in_ready_r & ~flush;
  assign pop_s  = out_valid_r & out_ready & ~flush;

`ifdef OPERAND_FIFO_PARITY_EN
  assign entry_s = {even_parity(in_data), in_data};
`else
  assign entry_s = in_data;
`endif

  // Next pointers, occupancy and head word; the head bypasses storage when the pushed word becomes the new head.
  always_comb begin
    wr_ptr_s = wr_ptr_r;
    rd_ptr_s = rd_ptr_r;
    count_s  = count_r;
    head_s   = out_data_r;
    if (flush) begin
      wr_ptr_s = '0;
      rd_ptr_s = '0;
      count_s  = '0;
    end else begin
      if (push_s) wr_ptr_s = wr_ptr_r + AW'(1);
      else        wr_ptr_s = wr_ptr_r;
      if (pop_s)  rd_ptr_s = rd_ptr_r + AW'(1);
      else        rd_ptr_s = rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_s = count_r + (AW+1)'(1);
        2'b01:   count_s = count_r - (AW+1)'(1);
        default: count_s = count_r;
      endcase
      if (push_s && ((count_r == (AW+1)'(0)) || ((count_r == (AW+1)'(1)) && pop_s)))
        head_s = in_data;
      else if (count_s != (AW+1)'(0))
        head_s = mem[rd_ptr_s][WIDTH-1:0];
      else
        head_s = out_data_r;
    end
  end

  // Storage array, intentionally without reset.
  always_ff @(posedge clk) begin
    if (push_s) mem[wr_ptr_r] <= entry_s;
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      out_data_r  <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      stall_r     <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_s;
      rd_ptr_r    <= rd_ptr_s;
      count_r     <= count_s;
      out_data_r  <= head_s;
      in_ready_r  <= (count_s != FULL_CNT);
      out_valid_r <= (count_s != (AW+1)'(0));
      stall_r     <= in_valid & ~in_ready_r;
      err_r       <= err_r | (stall_r & ~in_valid);
    end
  end

`ifdef OPERAND_FIFO_PARITY_EN
  logic parity_err_r;
  // Stored word plus parity bit must XOR to zero when it leaves the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          parity_err_r <= 1'b0;
    else if (flush)                      parity_err_r <= 1'b0;
    else if (pop_s && (^mem[rd_ptr_r]))  parity_err_r <= 1'b1;
    else                                 parity_err_r <= parity_err_r;
  end
  assign parity_err = parity_err_r;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign count     = count_r;
  assign err       = err_r;

endmodule
